// File: rtl/pwm_dac_driver.sv
// PWM output stage for an external RC DAC filter: captures generator samples,
// shapes/attenuates them and applies them as PWM duty only on period boundaries.
module pwm_dac_driver #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PRESCALE = 1
) (
  input  logic              CLKOSILLATOR,
  input  logic              RST,
  input  logic              ENB,
  input  logic [DATA_W-1:0] OUTPUTWAVE,
  input  logic              SAMPLE_STB,
  input  logic [2:0]        GAIN,
  input  logic              INVERT,
  input  logic              OVR_CLR,
  output logic              PWM_OUT,
  output logic [DATA_W-1:0] DUTY,
  output logic              PERIOD_END,
  output logic              OVERRUN
);

  localparam int unsigned DIV_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DATA_W-1:0] CNT_MAX = '1;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] duty_q, duty_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic              pwm_q, pwm_d;
  logic              period_end_q, period_end_d;
  logic              overrun_q, overrun_d;

  logic              tick_c;
  logic              wrap_c;
  logic              capture_c;
  logic [DATA_W-1:0] shaped_c;
  logic [DATA_W-1:0] processed_c;

  // Tick, wrap and sample shaping
  always_comb begin
    tick_c      = ENB && (div_q == DIV_W'(PRESCALE - 1));
    wrap_c      = tick_c && (cnt_q == CNT_MAX);
    capture_c   = SAMPLE_STB && ENB;
    shaped_c    = INVERT ? ~OUTPUTWAVE : OUTPUTWAVE;
    processed_c = shaped_c >> GAIN;
  end

  always_ff @(posedge CLKOSILLATOR or negedge RST) begin
    if (!RST) begin
      div_q        <= '0;
      cnt_q        <= '0;
      duty_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      pwm_q        <= 1'b0;
      period_end_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      duty_q       <= duty_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      pwm_q        <= pwm_d;
      period_end_q <= period_end_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    div_d        = div_q;
    cnt_d        = cnt_q;
    duty_d       = duty_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    overrun_d    = overrun_q;
    period_end_d = wrap_c;
    pwm_d        = ENB && (cnt_q < duty_q);

    if (ENB) begin
      div_d = tick_c ? '0 : div_q + DIV_W'(1);
    end
    if (tick_c) begin
      cnt_d = cnt_q + DATA_W'(1);
    end

    // Load uses the old pending value; a same-cycle capture refills it afterwards
    if (wrap_c && pend_valid_q) begin
      duty_d       = pend_q;
      pend_valid_d = 1'b0;
    end
    if (capture_c) begin
      pend_d       = processed_c;
      pend_valid_d = 1'b1;
    end

    if (capture_c && pend_valid_q && !wrap_c) begin
      overrun_d = 1'b1;
    end else if (OVR_CLR) begin
      overrun_d = 1'b0;
    end
  end

  assign PWM_OUT    = pwm_q;
  assign DUTY       = duty_q;
  assign PERIOD_END = period_end_q;
  assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_pwm_dac_driver.sv
// Bench for pwm_dac_driver: tick-count reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pwm_dac_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb, stb, inv, ovr_clr;
  logic [7:0] wave;
  logic [2:0] gain;

  logic       pwm, pe, ovr;
  logic [7:0] duty;
  logic       pwm4, pe4, ovr4;
  logic [7:0] duty4;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pwm_dac_driver #(.DATA_W(8), .PRESCALE(1)) u_dut (
    .CLKOSILLATOR(clk), .RST(rst), .ENB(enb), .OUTPUTWAVE(wave),
    .SAMPLE_STB(stb), .GAIN(gain), .INVERT(inv), .OVR_CLR(ovr_clr),
    .PWM_OUT(pwm), .DUTY(duty), .PERIOD_END(pe), .OVERRUN(ovr)
  );

  pwm_dac_driver #(.DATA_W(8), .PRESCALE(4)) u_dut4 (
    .CLKOSILLATOR(clk), .RST(rst), .ENB(enb), .OUTPUTWAVE(wave),
    .SAMPLE_STB(stb), .GAIN(gain), .INVERT(inv), .OVR_CLR(ovr_clr),
    .PWM_OUT(pwm4), .DUTY(duty4), .PERIOD_END(pe4), .OVERRUN(ovr4)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: position in the period is total ticks elapsed modulo 256
  int m_ticks, m_div, m_duty, m_pend;
  bit m_pv, m_ovr, m_pwm, m_pe;

  always @(posedge clk or negedge rst) begin
    int  pos;
    bit  tick, wrap, cap;
    if (!rst) begin
      m_ticks = 0; m_div = 0; m_duty = 0; m_pend = 0;
      m_pv = 0; m_ovr = 0; m_pwm = 0; m_pe = 0;
    end else begin
      pos   = m_ticks % 256;
      m_pwm = enb && (pos < m_duty);
      tick  = enb && (m_div == 0);
      wrap  = tick && (pos == 255);
      m_pe  = wrap;
      cap   = stb && enb;
      if (cap && m_pv && !wrap) m_ovr = 1;
      else if (ovr_clr)         m_ovr = 0;
      if (wrap && m_pv) begin
        m_duty = m_pend;
        m_pv   = 0;
      end
      if (cap) begin
        m_pend = (inv ? 255 - int'(wave) : int'(wave)) / (1 << gain);
        m_pv   = 1;
      end
      if (tick) m_ticks++;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("pwm_model",        int'(pwm),  int'(m_pwm));
      check("duty_model",       int'(duty), m_duty);
      check("period_end_model", int'(pe),   int'(m_pe));
      check("overrun_model",    int'(ovr),  int'(m_ovr));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [7:0] v, input logic [2:0] g, input logic i);
    wave = v; gain = g; inv = i; stb = 1'b1;
    cyc(1);
    stb = 1'b0;
  endtask

  task automatic wait_pe(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pe !== 1'b1 && n < 3000);
    #1;
  endtask

  task automatic wait_pe4(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pe4 !== 1'b1 && n < 5000);
    #1;
  endtask

  task automatic count_high(input int n, output int h);
    h = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm === 1'b1) h++;
    end
    #1;
  endtask

  initial begin
    int n, h;
    rst = 1'b0; enb = 1'b1; stb = 1'b0; inv = 1'b0; ovr_clr = 1'b0;
    wave = 8'h00; gain = 3'd0;
    cyc(3);
    check("rst_pwm", int'(pwm), 0);
    check("rst_duty", int'(duty), 0);
    check("rst_pe", int'(pe), 0);
    check("rst_ovr", int'(ovr), 0);
    rst = 1'b1;

    // First period after release: duty 0 gives no high clocks
    n = 0; h = 0;
    do begin
      @(negedge clk);
      n++;
      if (pwm === 1'b1) h++;
    end while (pe !== 1'b1 && n < 3000);
    #1;
    check("first_pe_latency", n, 256);
    check("duty0_highs", h, 0);

    strobe(8'h80, 3'd0, 1'b0);
    wait_pe(n);
    check("duty_80", int'(duty), 8'h80);
    count_high(256, h);
    check("highs_80", h, 128);

    // Reset in the middle of a high phase
    cyc(10);
    check("pwm_high_pre_rst", int'(pwm), 1);
    rst = 1'b0;
    #1;
    check("midrst_pwm", int'(pwm), 0);
    check("midrst_duty", int'(duty), 0);
    check("midrst_pe", int'(pe), 0);
    check("midrst_ovr", int'(ovr), 0);
    cyc(2);
    rst = 1'b1;
    wait_pe(n);
    check("pe_after_midrst", n, 256);

    strobe(8'h40, 3'd2, 1'b1);
    wait_pe(n);
    check("duty_2f", int'(duty), 8'h2F);
    count_high(256, h);
    check("highs_2f", h, 47);
    strobe(8'hFF, 3'd7, 1'b0);
    wait_pe(n);
    check("duty_01", int'(duty), 8'h01);
    strobe(8'hFF, 3'd0, 1'b0);
    wait_pe(n);
    check("duty_ff", int'(duty), 8'hFF);
    count_high(256, h);
    check("highs_ff", h, 255);

    strobe(8'h10, 3'd0, 1'b0);
    cyc(5);
    strobe(8'h20, 3'd0, 1'b0);
    check("ovr_set", int'(ovr), 1);
    wait_pe(n);
    check("duty_20", int'(duty), 8'h20);
    check("ovr_sticky", int'(ovr), 1);
    ovr_clr = 1'b1;
    cyc(1);
    ovr_clr = 1'b0;
    check("ovr_clr", int'(ovr), 0);

    // Strobe landing exactly on the wrap cycle
    wait_pe(n);
    strobe(8'h33, 3'd0, 1'b0);
    cyc(254);
    strobe(8'h55, 3'd0, 1'b0);
    check("pe_coinc", int'(pe), 1);
    check("duty_old_pend", int'(duty), 8'h33);
    check("ovr_coinc", int'(ovr), 0);
    wait_pe(n);
    check("duty_new_pend", int'(duty), 8'h55);
    check("ovr_after_coinc", int'(ovr), 0);

    // Disable at position 100 with duty 0xF0
    strobe(8'hF0, 3'd0, 1'b0);
    wait_pe(n);
    check("duty_f0", int'(duty), 8'hF0);
    cyc(100);
    check("pwm_pre_dis", int'(pwm), 1);
    enb = 1'b0;
    cyc(1);
    check("pwm_dis", int'(pwm), 0);
    cyc(24);
    strobe(8'h11, 3'd0, 1'b0);
    cyc(24);
    check("pwm_dis_late", int'(pwm), 0);
    check("pe_dis", int'(pe), 0);
    enb = 1'b1;
    wait_pe(n);
    check("wrap_after_reenable", n, 156);
    check("duty_ignored_stb", int'(duty), 8'hF0);
    check("ovr_ignored_stb", int'(ovr), 0);

    wait_pe4(n);
    wait_pe4(n);
    check("prescale4_period", n, 1024);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
